// File: rtl/t5_dec.sv
// t5_dec: decode stage for the 4-hart barrel RV32I pipeline.
// Registers the fetched word through a one-entry stall buffer.
module t5_dec #(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = 32'h00000013
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [XLEN-1:0] fpc,
  input  logic [31:0]     iwb_dat,
  input  logic            iwb_ack,
  output logic [XLEN-1:0] dpc,
  output logic [31:0]     dins,
  output logic [31:0]     dimm,
  output logic [4:0]      drs1,
  output logic [4:0]      drs2,
  output logic [4:0]      drd,
  output logic [4:0]      dop,
  output logic            dwre,
  output logic            dill,
  output logic            dval
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_FENCE = 5'b00011;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_OP    = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_SYS   = 5'b11100;

  logic            hold_vld_q, hold_vld_d;
  logic [31:0]     hold_dat_q, hold_dat_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic [31:0]     dins_q, dins_d;
  logic [31:0]     dimm_q, dimm_d;
  logic [4:0]      drs1_q, drs1_d;
  logic [4:0]      drs2_q, drs2_d;
  logic [4:0]      drd_q, drd_d;
  logic [4:0]      dop_q, dop_d;
  logic            dwre_q, dwre_d;
  logic            dill_q, dill_d;
  logic            dval_q, dval_d;

  logic [31:0] src;
  logic        valid;
  logic [4:0]  opc;
  logic [31:0] imm;
  logic        legal;
  logic        wr_op;

  // Pick the word entering decode: live ack, then held word, else bubble.
  always_comb begin
    src   = NOP;
    valid = 1'b0;
    if (iwb_ack) begin
      src   = iwb_dat;
      valid = 1'b1;
    end else if (hold_vld_q) begin
      src   = hold_dat_q;
      valid = 1'b1;
    end
  end

  assign opc = src[6:2];

  // Opcode classification and immediate formation.
  always_comb begin
    imm   = 32'h0;
    legal = 1'b0;
    wr_op = 1'b0;
    unique case (opc)
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm   = {{20{src[31]}}, src[31:20]};
        legal = 1'b1;
        wr_op = 1'b1;
      end
      OP_SYS: begin
        imm   = {{20{src[31]}}, src[31:20]};
        legal = 1'b1;
      end
      OP_STORE: begin
        imm   = {{20{src[31]}}, src[31:25], src[11:7]};
        legal = 1'b1;
      end
      OP_BR: begin
        imm   = {{19{src[31]}}, src[31], src[7],
                 src[30:25], src[11:8], 1'b0};
        legal = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm   = {src[31:12], 12'h0};
        legal = 1'b1;
        wr_op = 1'b1;
      end
      OP_JAL: begin
        imm   = {{11{src[31]}}, src[31], src[19:12],
                 src[20], src[30:21], 1'b0};
        legal = 1'b1;
        wr_op = 1'b1;
      end
      OP_OP: begin
        legal = 1'b1;
        wr_op = 1'b1;
      end
      OP_FENCE: begin
        legal = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (src[1:0] != 2'b11) legal = 1'b0;
  end

  // Next-state: hold buffer fills only while stalled; outputs move on sena.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    dpc_d      = dpc_q;
    dins_d     = dins_q;
    dimm_d     = dimm_q;
    drs1_d     = drs1_q;
    drs2_d     = drs2_q;
    drd_d      = drd_q;
    dop_d      = dop_q;
    dwre_d     = dwre_q;
    dill_d     = dill_q;
    dval_d     = dval_q;
    if (sena) begin
      hold_vld_d = 1'b0;
      dpc_d      = fpc;
      dins_d     = src;
      dimm_d     = imm;
      drs1_d     = src[19:15];
      drs2_d     = src[24:20];
      drd_d      = src[11:7];
      dop_d      = opc;
      dwre_d     = valid & legal & wr_op & (src[11:7] != 5'd0);
      dill_d     = valid & ~legal;
      dval_d     = valid;
    end else if (iwb_ack) begin
      hold_vld_d = 1'b1;
      hold_dat_d = iwb_dat;
    end
  end

  // State registers; reset wins over enable.
  always_ff @(posedge sclk) begin
    if (srst) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= 32'h0;
      dpc_q      <= '0;
      dins_q     <= NOP;
      dimm_q     <= 32'h0;
      drs1_q     <= 5'd0;
      drs2_q     <= 5'd0;
      drd_q      <= 5'd0;
      dop_q      <= 5'h04;
      dwre_q     <= 1'b0;
      dill_q     <= 1'b0;
      dval_q     <= 1'b0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      dpc_q      <= dpc_d;
      dins_q     <= dins_d;
      dimm_q     <= dimm_d;
      drs1_q     <= drs1_d;
      drs2_q     <= drs2_d;
      drd_q      <= drd_d;
      dop_q      <= dop_d;
      dwre_q     <= dwre_d;
      dill_q     <= dill_d;
      dval_q     <= dval_d;
    end
  end

  assign dpc  = dpc_q;
  assign dins = dins_q;
  assign dimm = dimm_q;
  assign drs1 = drs1_q;
  assign drs2 = drs2_q;
  assign drd  = drd_q;
  assign dop  = dop_q;
  assign dwre = dwre_q;
  assign dill = dill_q;
  assign dval = dval_q;

endmodule

// File: tb/tb_t5_dec.sv
// tb_t5_dec: directed checks of t5_dec against a behavioural
// model of issue order and RV32I immediate/legality rules.
module tb_t5_dec;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        sclk = 1'b0;
  logic        srst, sena, iwb_ack;
  logic [31:0] fpc, iwb_dat;
  logic [31:0] dpc, dins, dimm;
  logic [4:0]  drs1, drs2, drd, dop;
  logic        dwre, dill, dval;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  t5_dec dut (
    .sclk(sclk), .srst(srst), .sena(sena), .fpc(fpc),
    .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
    .dpc(dpc), .dins(dins), .dimm(dimm),
    .drs1(drs1), .drs2(drs2), .drd(drd), .dop(dop),
    .dwre(dwre), .dill(dill), .dval(dval)
  );

  always #5 sclk = ~sclk;

  // Model: which word was issued last, with what PC, and the
  // pending stalled word; decode fields derive from that word.
  logic        m_hv;
  logic [31:0] m_hd;
  logic [31:0] e_pc, e_ins;
  logic        e_val;

  always @(posedge sclk) begin
    if (srst) begin
      m_hv  <= 1'b0;
      m_hd  <= 32'h0;
      e_pc  <= 32'h0;
      e_ins <= NOP;
      e_val <= 1'b0;
    end else if (sena) begin
      m_hv <= 1'b0;
      e_pc <= fpc;
      if (iwb_ack) begin
        e_ins <= iwb_dat;
        e_val <= 1'b1;
      end else if (m_hv) begin
        e_ins <= m_hd;
        e_val <= 1'b1;
      end else begin
        e_ins <= NOP;
        e_val <= 1'b0;
      end
    end else if (iwb_ack) begin
      m_hv <= 1'b1;
      m_hd <= iwb_dat;
    end
  end

  function automatic bit m_legal(input logic [31:0] w);
    int op;
    op = int'(w[6:2]);
    return (w[1:0] == 2'b11) &&
      (op inside {0, 3, 4, 5, 8, 12, 13, 24, 25, 27, 28});
  endfunction

  function automatic bit m_wre(input logic [31:0] w, input bit v);
    int op;
    op = int'(w[6:2]);
    return v && m_legal(w) && (w[11:7] != 5'd0) &&
      (op inside {0, 4, 5, 12, 13, 25, 27});
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    int op, v;
    op = int'(w[6:2]);
    v  = 0;
    if (op inside {0, 4, 25, 28})
      v = int'($signed(w[31:20]));
    else if (op == 8)
      v = int'($signed({w[31:25], w[11:7]}));
    else if (op == 24)
      v = 2 * int'($signed({w[31], w[7], w[30:25], w[11:8]}));
    else if (op inside {5, 13})
      v = int'(w & 32'hFFFFF000);
    else if (op == 27)
      v = 2 * int'($signed({w[31], w[19:12], w[20], w[30:21]}));
    return 32'(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare every cycle against the model.
  always @(negedge sclk) begin
    if (chk_en) begin
      chk("m_dpc",  dpc,  e_pc);
      chk("m_dins", dins, e_ins);
      chk("m_dval", 32'(dval), 32'(e_val));
      chk("m_dimm", dimm, m_imm(e_ins));
      chk("m_drs1", 32'(drs1), 32'(e_ins[19:15]));
      chk("m_drs2", 32'(drs2), 32'(e_ins[24:20]));
      chk("m_drd",  32'(drd),  32'(e_ins[11:7]));
      chk("m_dop",  32'(dop),  32'(e_ins[6:2]));
      chk("m_dwre", 32'(dwre), 32'(m_wre(e_ins, e_val)));
      chk("m_dill", 32'(dill),
          32'(e_val && !m_legal(e_ins)));
    end
  end

  task automatic cyc(input logic s, input logic a,
                     input logic [31:0] d, input logic [31:0] pc);
    sena    = s;
    iwb_ack = a;
    iwb_dat = d;
    fpc     = pc;
    @(negedge sclk);
  endtask

  logic [31:0] mix [8] = '{
    32'hFE112E23, 32'h00000073, 32'h0FF0000F, 32'h002081B3,
    32'h12345297, 32'hFFC100E7, 32'h800000EF, 32'h80000C63
  };

  initial begin
    srst = 1'b1;
    chk_en = 1'b1;
    cyc(1, 1, 32'h00500113, 32'h00000044);
    cyc(1, 1, 32'h00500113, 32'h00000048);
    chk("rst_dins", dins, NOP);
    chk("rst_dval", 32'(dval), 32'd0);
    chk("rst_dwre", 32'(dwre), 32'd0);
    chk("rst_dpc",  dpc, 32'd0);
    chk("rst_dop",  32'(dop), 32'h04);
    srst = 1'b0;
    cyc(1, 0, 32'h0, 32'h00000010);
    chk("rst_nohold", 32'(dval), 32'd0);

    cyc(1, 1, 32'hFFF10093, 32'h00000102);
    chk("i_dimm", dimm, 32'hFFFFFFFF);
    chk("i_drs1", 32'(drs1), 32'd2);
    chk("i_drd",  32'(drd), 32'd1);
    chk("i_dwre", 32'(dwre), 32'd1);
    chk("i_dpc",  dpc, 32'h00000102);
    chk("i_dval", 32'(dval), 32'd1);

    cyc(1, 1, 32'hFE0008E3, 32'h00000106);
    chk("b_dimm", dimm, 32'hFFFFFFF0);
    chk("b_dwre", 32'(dwre), 32'd0);
    cyc(1, 1, 32'h0000006F, 32'h0000010A);
    chk("j_dimm", dimm, 32'h0);
    chk("j_drd",  32'(drd), 32'd0);
    chk("j_dwre", 32'(dwre), 32'd0);
    cyc(1, 1, 32'h123450B7, 32'h0000010E);
    chk("u_dimm", dimm, 32'h12345000);
    chk("u_dwre", 32'(dwre), 32'd1);

    cyc(0, 1, 32'h00500113, 32'h00000200);
    chk("stall_hold", dins, 32'h123450B7);
    cyc(0, 1, 32'h00600193, 32'h00000200);
    cyc(1, 0, 32'h0, 32'h00000200);
    chk("st_dins", dins, 32'h00600193);
    chk("st_dval", 32'(dval), 32'd1);
    cyc(1, 0, 32'h0, 32'h00000204);
    chk("st_bub_val", 32'(dval), 32'd0);
    chk("st_bub_ins", dins, NOP);

    cyc(0, 1, 32'h00500113, 32'h00000300);
    cyc(1, 1, 32'h00700213, 32'h00000300);
    chk("col_dins", dins, 32'h00700213);
    cyc(1, 0, 32'h0, 32'h00000304);
    chk("col_bub", 32'(dval), 32'd0);

    cyc(1, 1, 32'h00000000, 32'h00000401);
    chk("ill0_dill", 32'(dill), 32'd1);
    chk("ill0_dwre", 32'(dwre), 32'd0);
    chk("ill0_dval", 32'(dval), 32'd1);
    cyc(1, 1, 32'h0000007F, 32'h00000405);
    chk("ill1_dill", 32'(dill), 32'd1);
    chk("ill1_dwre", 32'(dwre), 32'd0);
    chk("ill1_dval", 32'(dval), 32'd1);
    cyc(1, 0, 32'h0, 32'h00000409);
    chk("ill_bub", 32'(dill), 32'd0);

    cyc(0, 1, 32'h00500113, 32'h00000500);
    srst = 1'b1;
    cyc(0, 0, 32'h0, 32'h00000500);
    srst = 1'b0;
    cyc(1, 0, 32'h0, 32'h00000504);
    chk("rst_stall", 32'(dval), 32'd0);

    for (int i = 0; i < 8; i++)
      cyc(1, 1, mix[i], 32'h600 + 32'(i * 4) + 32'(i % 4));
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          mix[$urandom_range(0, 7)] ^ ((i % 5 == 0) ? 32'h3 : 32'h0),
          32'($urandom));
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
